// File: rtl/serial_addsub_param_if.sv
// Serial operand/result bundle for the bit-serial adder/subtractor.
// The master drives the operand bits; the slave returns the result bits.
interface serial_addsub_param_if;
  logic en_i;
  logic ina;
  logic inb;
  logic sub_i;
  logic en_o;
  logic out;
  logic busy;

  modport master (output en_i, ina, inb, sub_i, input en_o, out, busy);
  modport slave  (input en_i, ina, inb, sub_i, output en_o, out, busy);
endinterface

// File: rtl/serial_addsub_param.sv
// MSB-first bit-serial adder/subtractor with a WIDTH-bit operand width.
// Produces a (WIDTH+1)-bit result and accepts back-to-back frames.
module serial_addsub_param #(
  parameter int WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_addsub_param_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_calc;
  logic [CW-1:0]    cnt;
  logic             sub_q;
  logic             sub_sel;
  logic             accept;
  logic             capture;
  logic             compute;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The last capture edge computes R from the bit arriving on that same edge.
  always_comb begin
    a_next     = (a_sr << 1) | WIDTH'(bus.ina);
    b_next     = (b_sr << 1) | WIDTH'(bus.inb);
    accept     = bus.en_i && (state == IDLE || state == FIN);
    sub_sel    = accept ? bus.sub_i : sub_q;
    capture    = accept || (state == LOAD);
    compute    = (accept && WIDTH == 1) || (state == LOAD && cnt == CW'(WIDTH - 1));
    r_calc     = sub_sel ? ({1'b0, a_next} - {1'b0, b_next})
                         : ({1'b0, a_next} + {1'b0, b_next});
    state_next = state;
    case (state)
      IDLE, FIN: begin
        if (accept) state_next = (WIDTH > 1) ? LOAD : SEND;
        else        state_next = IDLE;
      end
      LOAD:    if (compute) state_next = SEND;
      SEND:    if (cnt == CW'(WIDTH)) state_next = FIN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      r        <= '0;
      cnt      <= '0;
      sub_q    <= 1'b0;
      bus.en_o <= 1'b0;
      bus.out  <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      if (capture) begin
        a_sr <= a_next;
        b_sr <= b_next;
      end
      if (accept) sub_q <= bus.sub_i;
      if (compute)                          cnt <= '0;
      else if (accept)                      cnt <= CW'(1);
      else if (state == LOAD || state == SEND) cnt <= cnt + CW'(1);
      else                                  cnt <= '0;
      // R is shifted left while sending so its MSB is always the next bit out.
      if (compute)            r <= r_calc;
      else if (state == SEND) r <= r << 1;
      bus.en_o <= (state == SEND);
      bus.out  <= (state == SEND) && r[WIDTH];
      bus.busy <= (state_next != IDLE);
    end
  end

endmodule
